uart_tx_arbiter: RTL

- Shares one UART transmit byte port (UARTDriver tx_data valid/ready/bits) among N byte-stream requesters, such as the CPU console, debug monitor and DMA log.
- Grants are round-robin at packet granularity. A grant is held until the requester sends a byte flagged last, so packets are never interleaved.
- When enabled, a one-byte source-ID header is emitted ahead of each packet so the host side can demultiplex the streams.
- Sits between the requesters and the UART driver TX data interface.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit path: byte type, arbiter states and a grant-width helper.
package uart_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_HEADER,
    ARB_DATA
  } arb_state_t;

  // An index into n requesters needs at least one bit, even when n is 1.
  function automatic int unsigned grant_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-driver handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  import uart_pkg::*;

  localparam int unsigned GW = grant_width(N_REQ);

  logic [N_REQ-1:0]   i_req_valid;
  logic [N_REQ*8-1:0] i_req_data;
  logic [N_REQ-1:0]   i_req_last;
  logic [N_REQ-1:0]   o_req_ready;
  logic               o_tx_valid;
  byte_t              o_tx_data;
  logic               i_tx_ready;
  logic               o_busy;
  logic [GW-1:0]      o_grant;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_valid, o_tx_data, o_busy, o_grant
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_valid, o_tx_data, o_busy, o_grant
  );

endinterface

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first requester above last_grant, wrapping to index 0.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned GW   = grant_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_last_grant,
  output logic [GW-1:0]    o_winner,
  output logic             o_any
);

  logic found;

  // Pass one covers indices above last_grant, pass two covers the wrap.
  always_comb begin
    found    = 1'b0;
    o_winner = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && (i > int'(i_last_grant)) && i_req[i]) begin
        found    = 1'b1;
        o_winner = GW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && i_req[i]) begin
        found    = 1'b1;
        o_winner = GW'(i);
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte port, with optional ID header.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter bit          HEADER_EN   = 1'b1,
  parameter byte_t       HEADER_BASE = 8'hF0
) (
  input logic              i_clock,
  input logic              i_reset_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned GW = grant_width(N_REQ);

  arb_state_t       state_q;
  logic [GW-1:0]    grant_q;
  logic [GW-1:0]    last_grant_q;
  logic             tx_valid_q;
  byte_t            tx_data_q;

  logic [GW-1:0]    pick;
  logic             any_req;
  logic             slot_free;
  logic             sel_valid;
  logic             sel_last;
  byte_t            sel_data;
  logic             load_en;
  byte_t            load_byte;
  logic [N_REQ-1:0] ready_d;

  uart_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .i_req        (bus.i_req_valid),
    .i_last_grant (last_grant_q),
    .o_winner     (pick),
    .o_any        (any_req)
  );

  assign slot_free = !tx_valid_q || bus.i_tx_ready;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        sel_valid = bus.i_req_valid[i];
        sel_last  = bus.i_req_last[i];
        sel_data  = bus.i_req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    load_en   = 1'b0;
    load_byte = sel_data;
    ready_d   = '0;
    unique case (state_q)
      ARB_HEADER: begin
        load_en   = slot_free;
        load_byte = HEADER_BASE + byte_t'(grant_q);
      end
      ARB_DATA: begin
        load_en = slot_free && sel_valid;
        for (int i = 0; i < N_REQ; i++) begin
          if (grant_q == GW'(i)) ready_d[i] = slot_free;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(N_REQ - 1);
      tx_valid_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      if (load_en) begin
        tx_valid_q <= 1'b1;
        tx_data_q  <= load_byte;
      end else if (bus.i_tx_ready) begin
        tx_valid_q <= 1'b0;
      end

      unique case (state_q)
        ARB_IDLE: begin
          if (any_req) begin
            grant_q <= pick;
            state_q <= HEADER_EN ? ARB_HEADER : ARB_DATA;
          end
        end
        ARB_HEADER: begin
          if (slot_free) state_q <= ARB_DATA;
        end
        ARB_DATA: begin
          // Grant is held until the owner's last byte, however long it stalls.
          if (load_en && sel_last) begin
            last_grant_q <= grant_q;
            state_q      <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = ready_d;
  assign bus.o_tx_valid  = tx_valid_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_busy      = (state_q != ARB_IDLE) || tx_valid_q;
  assign bus.o_grant     = grant_q;

endmodule
